// File: rtl/gru_state_streamer.sv
// gru_state_streamer: captures a parallel GRU state vector in one cycle and
// streams it out one element per transfer over a valid/ready handshake.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   load, vec_in   : capture request and N*FLOAT-bit parallel vector
//   out_data       : current element (zero while out_valid is low)
//   out_valid      : out_data holds a valid element
//   out_ready      : downstream accepts the current element
//   out_index      : index of the current element (zero while idle)
//   out_last       : current element is index N-1
//   busy           : a vector is being streamed
//   done           : one-cycle pulse after the final transfer
//   load_err       : one-cycle pulse when a load arrives mid-stream
module gru_state_streamer #(
  parameter int FLOAT = 32,
  parameter int N     = 24,
  parameter int IDXW  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [N*FLOAT-1:0]   vec_in,
  output logic [FLOAT-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 load_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  logic [N*FLOAT-1:0]  buf_q;
  logic [N*FLOAT-1:0]  buf_shifted;
  logic                xfer;
  logic                final_xfer;
  logic                accept;

  // Buffer always keeps the current element in its low FLOAT bits.
  assign buf_shifted = buf_q >> FLOAT;

  assign xfer       = out_valid & out_ready;
  assign final_xfer = xfer & out_last;
  // A load is taken when idle, or in the cycle of the final transfer so
  // consecutive vectors stream without a gap.
  assign accept     = load & ((state == IDLE) | final_xfer);

  // Valid and busy are both exactly the SEND state, which is a flop.
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);

  // Streaming FSM with registered outputs; buffer intentionally not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (accept) begin
        state     <= SEND;
        buf_q     <= vec_in;
        out_data  <= vec_in[FLOAT-1:0];
        out_index <= '0;
        out_last  <= (N == 1);
        done      <= final_xfer;
      end else if (final_xfer) begin
        state     <= IDLE;
        out_data  <= '0;
        out_index <= '0;
        out_last  <= 1'b0;
        done      <= 1'b1;
      end else if (xfer) begin
        buf_q     <= buf_shifted;
        out_data  <= buf_shifted[FLOAT-1:0];
        out_index <= out_index + IDXW'(1);
        // Next element is last when the current one is N-2.
        out_last  <= (out_index == IDXW'(N - 2));
      end
      // Any load not taken can only have arrived mid-stream.
      if (load && !accept) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gru_state_streamer.sv
// Bench for gru_state_streamer: an element-array model checked every cycle,
// directed scenarios with literal expectations, and a transfer log.
module tb_gru_state_streamer;

  localparam int N  = 24;
  localparam int FW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [N*FW-1:0] vec_in;
  logic [FW-1:0]   out_data;
  logic            out_valid;
  logic            ready;
  logic [6:0]      out_index;
  logic            out_last;
  logic            busy;
  logic            done;
  logic            load_err;

  logic            load1;
  logic [FW-1:0]   v1;
  logic [FW-1:0]   d1;
  logic            valid1;
  logic [6:0]      idx1;
  logic            last1;
  logic            busy1;
  logic            done1;
  logic            err1;

  always #5 clk = ~clk;

  gru_state_streamer #(.FLOAT(FW), .N(N), .IDXW(7)) dut (
    .clk(clk), .rst(rst), .load(load), .vec_in(vec_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(ready),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .done(done), .load_err(load_err)
  );

  gru_state_streamer #(.FLOAT(FW), .N(1), .IDXW(7)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .vec_in(v1),
    .out_data(d1), .out_valid(valid1), .out_ready(1'b1),
    .out_index(idx1), .out_last(last1), .busy(busy1),
    .done(done1), .load_err(err1)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: a captured vector, a read pointer and two pulses.
  logic [FW-1:0] m_vec [N];
  int  m_idx  = 0;
  bit  m_busy = 1'b0;
  bit  m_done = 1'b0;
  bit  m_err  = 1'b0;

  always @(posedge clk) begin
    bit fin, acc;
    if (rst) begin
      m_busy = 1'b0; m_idx = 0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      fin    = m_busy && ready && (m_idx == N - 1);
      acc    = load && (!m_busy || fin);
      m_done = fin;
      m_err  = load && !acc;
      if (acc) begin
        for (int k = 0; k < N; k++) m_vec[k] = vec_in[k*FW +: FW];
        m_busy = 1'b1; m_idx = 0;
      end else if (fin) begin
        m_busy = 1'b0; m_idx = 0;
      end else if (m_busy && ready) begin
        m_idx++;
      end
    end
  end

  // Log of every transfer the downstream actually sees.
  logic [FW-1:0] log_d [$];
  int            log_i [$];
  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && ready === 1'b1) begin
      log_d.push_back(out_data);
      log_i.push_back(int'(out_index));
    end
  end

  // Per-cycle compare against the model, plus stall-hold checks.
  logic          p_stall = 1'b0;
  logic [FW-1:0] p_data;
  logic [6:0]    p_idx;
  always @(negedge clk) begin
    if (started) begin
      chk("valid", out_valid, m_busy);
      chk("busy", busy, m_busy);
      chk("data", out_data, m_busy ? m_vec[m_idx] : '0);
      chk("index", out_index, m_busy ? m_idx : 0);
      chk("last", out_last, m_busy && (m_idx == N - 1));
      chk("done", done, m_done);
      chk("load_err", load_err, m_err);
      if (p_stall) begin
        chk("hold data", out_data, p_data);
        chk("hold index", out_index, p_idx);
      end
    end
    p_stall = out_valid && !ready && !rst;
    p_data  = out_data;
    p_idx   = out_index;
  end

  task automatic set_vec(input logic [FW-1:0] base);
    for (int k = 0; k < N; k++) vec_in[k*FW +: FW] = base + FW'(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [FW-1:0] base);
    set_vec(base);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
    end
    chk({nm, " done seen"}, ok, 1'b1);
  endtask

  task automatic wait_index(input string nm, input int target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid && int'(out_index) == target) begin ok = 1'b1; break; end
      tick();
    end
    chk({nm, " index reached"}, ok, 1'b1);
  endtask

  task automatic chk_log(input string nm, input logic [FW-1:0] b0,
                         input logic [FW-1:0] b1, input int nvec);
    chk({nm, " log count"}, log_d.size(), nvec * N);
    for (int v = 0; v < nvec; v++)
      for (int k = 0; k < N; k++) begin
        int pos = v * N + k;
        if (pos < log_d.size()) begin
          chk({nm, " log data"}, log_d[pos], (v == 0 ? b0 : b1) + FW'(k));
          chk({nm, " log index"}, log_i[pos], k);
        end
      end
    log_d.delete();
    log_i.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; ready = 1'b0; vec_in = '0;
    load1 = 1'b0; v1 = '0;
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset valid", out_valid, 1'b0);
    chk("reset data", out_data, 32'h0);
    chk("reset n1 valid", valid1, 1'b0);
    tick();

    // Basic stream with vec_in scrambled after capture.
    ready = 1'b1;
    do_load(32'h3F80_0000);
    vec_in = {N{32'hA5A5_A5A5}};
    chk("basic first data", out_data, 32'h3F80_0000);
    chk("basic first index", out_index, 7'd0);
    chk("basic first last", out_last, 1'b0);
    for (int i = 0; i < 23; i++) tick();
    chk("basic idx23", out_index, 7'd23);
    chk("basic last23", out_last, 1'b1);
    chk("basic data23", out_data, 32'h3F80_0017);
    tick();
    chk("basic done", done, 1'b1);
    chk("basic busy low", busy, 1'b0);
    tick();
    chk("basic done one cycle", done, 1'b0);
    chk_log("basic", 32'h3F80_0000, '0, 1);

    // Backpressure with ready pattern 1,0,0,1.
    begin
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit ok = 1'b0;
      ready = 1'b1;
      do_load(32'h4000_0000);
      for (int c = 0; c < 200; c++) begin
        ready = pat[c % 4];
        tick();
        if (done) begin ok = 1'b1; break; end
      end
      chk("bp done seen", ok, 1'b1);
      chk_log("bp", 32'h4000_0000, '0, 1);
    end

    // Back-to-back: second load in the final-transfer cycle.
    ready = 1'b1;
    do_load(32'h1000_0000);
    wait_index("b2b", 23, 50);
    set_vec(32'h2000_0000);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("b2b done", done, 1'b1);
    chk("b2b valid", out_valid, 1'b1);
    chk("b2b index0", out_index, 7'd0);
    chk("b2b data0", out_data, 32'h2000_0000);
    wait_done("b2b", 50);
    chk_log("b2b", 32'h1000_0000, 32'h2000_0000, 2);
    tick();

    // Rejected load at index 5.
    do_load(32'h3000_0000);
    wait_index("rej", 5, 20);
    set_vec(32'h7000_0000);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("rej load_err", load_err, 1'b1);
    chk("rej index", out_index, 7'd6);
    chk("rej data", out_data, 32'h3000_0006);
    tick();
    chk("rej load_err one cycle", load_err, 1'b0);
    wait_done("rej", 50);
    chk_log("rej", 32'h3000_0000, '0, 1);
    tick();

    // Reset at index 10, then restart.
    do_load(32'h5000_0000);
    wait_index("rst", 10, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    tick();
    chk("rst no late done", done, 1'b0);
    log_d.delete();
    log_i.delete();
    do_load(32'h6000_0000);
    chk("rst restart index", out_index, 7'd0);
    chk("rst restart data", out_data, 32'h6000_0000);
    wait_done("rst restart", 50);
    chk_log("rst restart", 32'h6000_0000, '0, 1);
    ready = 1'b0;
    tick();

    // N=1 instance.
    v1 = 32'hDEAD_BEEF;
    load1 = 1'b1;
    tick();
    load1 = 1'b0;
    chk("n1 valid", valid1, 1'b1);
    chk("n1 last", last1, 1'b1);
    chk("n1 index", idx1, 7'd0);
    chk("n1 data", d1, 32'hDEAD_BEEF);
    chk("n1 busy", busy1, 1'b1);
    tick();
    chk("n1 done", done1, 1'b1);
    chk("n1 valid low", valid1, 1'b0);
    chk("n1 data zero", d1, 32'h0);
    tick();
    chk("n1 done one cycle", done1, 1'b0);
    chk("n1 no err", err1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gru_state_streamer.md
GRU_STATE_STREAMER -- requirements
Module: gru_state_streamer

Interface
REQ-001 SHALL have parameter FLOAT, default 32, meaning bits per element.
REQ-002 SHALL have parameter N, default 24, meaning elements per vector; legal range 1..127.
REQ-003 SHALL have parameter IDXW, default 7, meaning element-index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port load, input, 1 bit: request to capture vec_in.
REQ-007 SHALL have port vec_in, input, N*FLOAT bits: parallel GRU state vector; element k occupies bits [k*FLOAT +: FLOAT].
REQ-008 SHALL have port out_data, output, FLOAT bits: current element.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the element.
REQ-011 SHALL have port out_index, output, IDXW bits: index of the current element.
REQ-012 SHALL have port out_last, output, 1 bit: current element is index N-1.
REQ-013 SHALL have port busy, output, 1 bit: a vector is being streamed.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the final transfer.
REQ-015 SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-016 SHALL implement states IDLE and SEND; busy=1 exactly in SEND.
REQ-017 SHALL accept a load when in IDLE, or in SEND in the cycle of the final transfer (valid&ready&last), so back-to-back vectors stream gaplessly.
REQ-018 SHALL, on an accepted load at edge t, register all of vec_in into an internal N*FLOAT buffer, enter SEND, and present element 0 with out_valid=1 at t+1 (latency 1 cycle).
REQ-019 SHALL define a transfer as out_valid=1 and out_ready=1 at a rising edge.
REQ-020 SHALL hold out_data, out_index and out_last stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on a non-final transfer, advance out_index by 1 and present the next element in the following cycle; sustained out_ready=1 yields one element per cycle.
REQ-022 SHALL assert out_last iff out_valid=1 and out_index=N-1; for N=1, out_last is 1 on element 0.
REQ-023 SHALL, on the final transfer without a simultaneous load, return to IDLE, drive out_valid=0 and busy=0, and pulse done=1 for exactly one cycle, all in the following cycle.
REQ-024 SHALL, on the final transfer with a simultaneous load, pulse done=1, stay in SEND, present element 0 of the new vector with out_index=0 the following cycle.
REQ-025 SHALL, on a load in SEND other than the REQ-017 case, ignore vec_in, leave the buffer and stream unchanged, and pulse load_err=1 the following cycle.
REQ-026 SHALL ignore vec_in changes after capture; streamed data comes only from the buffer.
REQ-027 SHALL drive out_data=0, out_index=0 and out_last=0 while out_valid=0.
REQ-028 SHALL never wrap out_index beyond N-1.
REQ-029 SHALL pass element bits unchanged, with no float interpretation or rounding.

Reset
REQ-030 SHALL, with rst=1 at a rising edge, enter IDLE and drive out_valid=0, busy=0, done=0, load_err=0, out_index=0, out_last=0 and out_data=0 the following cycle.
REQ-031 SHALL give rst priority over load and over any transfer in the same cycle; a stream cut mid-vector is discarded with no done pulse.
REQ-032 SHALL leave buffer contents undefined after reset; they are never visible on out_data until the next accepted load.

Verification
REQ-033 SHALL verify basic stream: N=24, element k=32'h3F800000+k, load pulse, out_ready=1 -> element 0 at t+1, 24 consecutive transfers, out_last only on index 23, done at t+25, busy low at t+25.
REQ-034 SHALL verify backpressure: out_ready toggled 1,0,0,1 pattern -> out_data/out_index held during stalls, no element lost or duplicated, order 0..23.
REQ-035 SHALL verify back-to-back: second load asserted in the final-transfer cycle with different vec_in -> no idle gap, done pulse, second vector element 0 follows index 23 directly.
REQ-036 SHALL verify rejected load: load at index 5 with new vec_in -> load_err pulse next cycle, remaining elements 5..23 come from the original vector.
REQ-037 SHALL verify reset mid-stream: rst at index 10 -> next cycle out_valid=0, busy=0, no done; a subsequent load restarts at index 0.
REQ-038 SHALL verify N=1: load -> single transfer with out_last=1, done the next cycle.
